// File: rtl/mandel_iter_ctrl.sv
// Mandelbrot escape-time iteration controller.
// Iterates z <- z*z + c on ws-bit two's-complement fixed-point words with dp
// fraction bits, using a single shared multiplier that is time-multiplexed
// over four states per iteration (zr*zr, zi*zi, zr*zi, then update/test).
//
// Handshake: start is sampled only while busy=0 (state IDLE). busy stays high
// from the cycle after acceptance through the final UPD cycle. done is a
// one-cycle strobe in the first idle cycle, and a new start may be accepted in
// that same cycle. escaped/iter_out/z_out stay valid until the next done.
module mandel_iter_ctrl #(
    parameter int ws = 16,
    parameter int dp = 8,
    parameter int iw = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [2*ws-1:0]   c_in,
    input  logic [iw-1:0]     max_iter,
    output logic              busy,
    output logic              done,
    output logic              escaped,
    output logic [iw-1:0]     iter_out,
    output logic [2*ws-1:0]   z_out,
    output logic [2:0]        dbg_state_o
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_MRR  = 3'd1,
        S_MII  = 3'd2,
        S_MRI  = 3'd3,
        S_UPD  = 3'd4
    } state_t;

    // Escape threshold 4.0 in the widened (ws+1 bit) sum domain.
    localparam logic signed [ws:0] FOUR = (ws+1)'(4 << dp);

    state_t state_q, state_d;

    logic signed [ws-1:0] zr_q, zi_q;
    logic signed [ws-1:0] cr_q, ci_q;
    logic signed [ws-1:0] rr_q, ii_q, ri_q;
    logic [iw-1:0]        max_q;
    logic [iw-1:0]        cnt_q;

    logic                 done_q;
    logic                 esc_q;
    logic [iw-1:0]        iter_q;
    logic [2*ws-1:0]      zout_q;

    // Shared multiplier: full-width signed product, then shift out dp
    // fraction bits and keep the low ws bits.
    logic signed [ws-1:0]   mul_a, mul_b;
    logic signed [2*ws-1:0] mul_full;
    logic signed [ws-1:0]   mul_p;

    assign mul_full = mul_a * mul_b;
    assign mul_p    = ws'(mul_full >>> dp);

    // Magnitude test sum is one bit wider so rr+ii can never wrap.
    logic signed [ws:0]   s_sum;
    logic                 s_gt4;
    logic                 cnt_at_max;
    logic                 terminate;
    logic signed [ws-1:0] zr_next, zi_next;

    assign s_sum      = {rr_q[ws-1], rr_q} + {ii_q[ws-1], ii_q};
    assign s_gt4      = (s_sum > FOUR);
    assign cnt_at_max = (cnt_q == max_q);
    assign terminate  = s_gt4 || cnt_at_max;
    assign zr_next    = rr_q - ii_q + cr_q;
    assign zi_next    = ri_q + ri_q + ci_q;

    // State register with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic: fixed four-state loop per iteration.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (start) state_d = S_MRR;
            S_MRR:   state_d = S_MII;
            S_MII:   state_d = S_MRI;
            S_MRI:   state_d = S_UPD;
            S_UPD:   state_d = terminate ? S_IDLE : S_MRR;
            default: state_d = S_IDLE;
        endcase
    end

    // Output logic: busy flag and multiplier operand selection.
    always_comb begin
        busy  = (state_q != S_IDLE);
        mul_a = zr_q;
        mul_b = zr_q;
        case (state_q)
            S_MRR: begin
                mul_a = zr_q;
                mul_b = zr_q;
            end
            S_MII: begin
                mul_a = zi_q;
                mul_b = zi_q;
            end
            S_MRI: begin
                mul_a = zr_q;
                mul_b = zi_q;
            end
            default: begin
                mul_a = zr_q;
                mul_b = zr_q;
            end
        endcase
    end

    // Datapath: latch operands, capture partial products, update z and
    // register the result on termination.
    always_ff @(posedge clk) begin
        if (rst) begin
            zr_q   <= '0;
            zi_q   <= '0;
            cr_q   <= '0;
            ci_q   <= '0;
            rr_q   <= '0;
            ii_q   <= '0;
            ri_q   <= '0;
            max_q  <= '0;
            cnt_q  <= '0;
            done_q <= 1'b0;
            esc_q  <= 1'b0;
            iter_q <= '0;
            zout_q <= '0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        cr_q  <= c_in[ws-1:0];
                        ci_q  <= c_in[2*ws-1:ws];
                        max_q <= max_iter;
                        zr_q  <= '0;
                        zi_q  <= '0;
                        cnt_q <= '0;
                    end
                end
                S_MRR: rr_q <= mul_p;
                S_MII: ii_q <= mul_p;
                S_MRI: ri_q <= mul_p;
                S_UPD: begin
                    if (terminate) begin
                        done_q <= 1'b1;
                        esc_q  <= s_gt4;
                        iter_q <= cnt_q;
                        zout_q <= {zi_q, zr_q};
                    end else begin
                        zr_q  <= zr_next;
                        zi_q  <= zi_next;
                        cnt_q <= cnt_q + iw'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    assign done        = done_q;
    assign escaped     = esc_q;
    assign iter_out    = iter_q;
    assign z_out       = zout_q;
    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_mandel_iter_ctrl.sv
// Testbench for mandel_iter_ctrl: directed evaluations with hand-computed
// results; a monitor compares each done strobe against the expected queue,
// including the edge on which done becomes visible.
module tb_mandel_iter_ctrl;

    localparam int WS = 16;
    localparam int DP = 8;
    localparam int IW = 8;
    localparam int EW = 1 + IW + 2*WS;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic            start = 1'b0;
    logic [2*WS-1:0] c_in = '0;
    logic [IW-1:0]   max_iter = '0;
    logic            busy, done, escaped;
    logic [IW-1:0]   iter_out;
    logic [2*WS-1:0] z_out;
    logic [2:0]      dbg_state;

    mandel_iter_ctrl #(.ws(WS), .dp(DP), .iw(IW)) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .c_in        (c_in),
        .max_iter    (max_iter),
        .busy        (busy),
        .done        (done),
        .escaped     (escaped),
        .iter_out    (iter_out),
        .z_out       (z_out),
        .dbg_state_o (dbg_state)
    );

    int edge_cnt = 0;
    always @(posedge clk) edge_cnt <= edge_cnt + 1;

    int checks = 0;
    int errors = 0;

    // ---------------- scoreboard ----------------
    logic [EW-1:0] exp_q[$];
    int            exp_cyc_q[$];

    always @(negedge clk) begin
        logic [EW-1:0] exp_v;
        int            exp_e;
        if (done) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_done at edge %0d: got done=1 with nothing expected", edge_cnt);
            end else begin
                exp_v = exp_q.pop_front();
                exp_e = exp_cyc_q.pop_front();
                checks++;
                if ({escaped, iter_out, z_out} !== exp_v) begin
                    errors++;
                    $display("FAIL result: got esc=%0d iter=%0d z=%h, expected esc=%0d iter=%0d z=%h",
                             escaped, iter_out, z_out, exp_v[EW-1], exp_v[EW-2 -: IW], exp_v[2*WS-1:0]);
                end
                checks++;
                if (edge_cnt !== exp_e) begin
                    errors++;
                    $display("FAIL done_timing: done after edge %0d, expected after edge %0d", edge_cnt, exp_e);
                end
                checks++;
                if (busy !== 1'b0) begin
                    errors++;
                    $display("FAIL busy_in_done: got busy=%0d, expected 0", busy);
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 400 && busy !== 1'b0; i++) @(negedge clk);
        if (busy !== 1'b0) begin
            checks++;
            errors++;
            $display("FAIL idle_timeout: busy=%0d, expected 0", busy);
        end
    endtask

    task automatic wait_drain(input int limit);
        for (int i = 0; i < limit && exp_q.size() != 0; i++) @(negedge clk);
        if (exp_q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL done_timeout: %0d results outstanding, expected 0", exp_q.size());
            exp_q.delete();
            exp_cyc_q.delete();
        end
    endtask

    task automatic push_exp(input logic e_esc, input logic [IW-1:0] e_it,
                            input logic [WS-1:0] e_zr, input logic [WS-1:0] e_zi,
                            input int done_edge);
        exp_q.push_back({e_esc, e_it, e_zi, e_zr});
        exp_cyc_q.push_back(done_edge);
    endtask

    // One evaluation: c = (cr, ci), limit mi; expected escape/iter/z.
    task automatic run_eval(input logic [WS-1:0] cr, input logic [WS-1:0] ci,
                            input logic [IW-1:0] mi, input logic e_esc,
                            input logic [IW-1:0] e_it, input logic [WS-1:0] e_zr,
                            input logic [WS-1:0] e_zi);
        wait_idle();
        c_in     = {ci, cr};
        max_iter = mi;
        start    = 1'b1;
        push_exp(e_esc, e_it, e_zr, e_zi, edge_cnt + 1 + 4*(int'(e_it) + 1));
        @(negedge clk);
        start = 1'b0;
        wait_drain(400);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int a;
        repeat (3) @(negedge clk);
        chk("reset_busy",    64'(busy),      64'd0);
        chk("reset_done",    64'(done),      64'd0);
        chk("reset_escaped", 64'(escaped),   64'd0);
        chk("reset_iter",    64'(iter_out),  64'd0);
        chk("reset_z",       64'(z_out),     64'd0);
        chk("reset_state",   64'(dbg_state), 64'd0);
        rst = 1'b0;
        @(negedge clk);

        // max_iter = 0: terminates in the first UPD regardless of c.
        run_eval(16'h0080, 16'h0080, 8'd0, 1'b0, 8'd0, 16'h0000, 16'h0000);
        // c = 0: z stays 0, limit reached at 10.
        run_eval(16'h0000, 16'h0000, 8'd10, 1'b0, 8'd10, 16'h0000, 16'h0000);
        // c = 1.0: z = 0,1,2,5 -> escapes with |z|^2 = 25.
        run_eval(16'h0100, 16'h0000, 8'd10, 1'b1, 8'd3, 16'h0500, 16'h0000);
        // c = -2.0: z settles at 2.0, s = 4.0 exactly never escapes.
        run_eval(16'hFE00, 16'h0000, 8'd5, 1'b0, 8'd5, 16'h0200, 16'h0000);
        // c = i: period-2 orbit -1+i / -i, stops at 6 with z = -1+i.
        run_eval(16'h0000, 16'h0100, 8'd6, 1'b0, 8'd6, 16'hFF00, 16'h0100);
        // c = -2.5: escapes on the real square at count 1.
        run_eval(16'hFD80, 16'h0000, 8'd10, 1'b1, 8'd1, 16'hFD80, 16'h0000);
        // c = 2.5i: escapes on the imaginary square at count 1.
        run_eval(16'h0000, 16'h0280, 8'd10, 1'b1, 8'd1, 16'h0000, 16'h0280);
        // Escape takes precedence when it coincides with the limit.
        run_eval(16'h0100, 16'h0000, 8'd3, 1'b1, 8'd3, 16'h0500, 16'h0000);

        // Reset while in MII aborts without a done pulse and clears outputs.
        wait_idle();
        c_in = {16'h0000, 16'h0100};
        max_iter = 8'd10;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        chk("abort_in_mii", 64'(dbg_state), 64'd2);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("abort_busy",    64'(busy),     64'd0);
        chk("abort_escaped", 64'(escaped),  64'd0);
        chk("abort_iter",    64'(iter_out), 64'd0);
        chk("abort_z",       64'(z_out),    64'd0);
        repeat (20) @(negedge clk);
        run_eval(16'h0100, 16'h0000, 8'd10, 1'b1, 8'd3, 16'h0500, 16'h0000);

        // Reset wins over a simultaneous start.
        rst = 1'b1;
        start = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        start = 1'b0;
        chk("rst_over_start_busy",  64'(busy),      64'd0);
        chk("rst_over_start_state", 64'(dbg_state), 64'd0);
        @(negedge clk);
        chk("rst_over_start_idle",  64'(busy),      64'd0);

        // start held high: extra starts ignored while busy, restart in done cycle.
        wait_idle();
        c_in = {16'h0000, 16'h0100};
        max_iter = 8'd10;
        start = 1'b1;
        a = edge_cnt + 1;
        push_exp(1'b1, 8'd3, 16'h0500, 16'h0000, a + 16);
        push_exp(1'b1, 8'd3, 16'h0500, 16'h0000, a + 17 + 16);
        for (int i = 0; i < 100 && edge_cnt < a + 33; i++) @(negedge clk);
        start = 1'b0;
        wait_drain(200);
        repeat (10) @(negedge clk);

        chk("scoreboard_empty", 64'(exp_q.size()), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // Global watchdog so the run always ends.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $display("Simulation finished: %0d checks, %0d errors", checks, errors + 1);
        $finish;
    end

endmodule
